// File: rtl/cmd_respond_pkg.sv
// Shared types and constants for the command/response engine.
package cmd_respond_pkg;

    typedef enum logic [1:0] {
        OpRead      = 2'd0,
        OpWrite     = 2'd1,
        OpBurstRead = 2'd2,
        OpRsvd      = 2'd3
    } op_e;

    localparam logic [3:0] HDR_SYNC = 4'hA;

    typedef enum logic [2:0] {
        StIdle,
        StDecode,
        StSendHdr,
        StRdIssue,
        StRdCapt,
        StSendData
    } state_e;

    // Command word layout for the default configuration; fields from MSB.
    localparam int unsigned CMD_DATA_W = 32;
    localparam int unsigned CMD_ADDR_W = 8;
    localparam int unsigned CMD_LEN_W  = 4;

    typedef struct packed {
        op_e                   op;
        logic [CMD_LEN_W-1:0]  len;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] wdata;
    } cmd_t;

    function automatic logic [7:0] make_header(input logic err, input op_e op);
        return {HDR_SYNC, 1'b0, err, op};
    endfunction

endpackage

// File: rtl/cmd_respond_engine_if.sv
// Command FIFO, register-bank and UART-transmit signals of the engine.
interface cmd_respond_engine_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned LEN_W  = 4
);
    localparam int unsigned CMD_W = 2 + LEN_W + ADDR_W + DATA_W;

    logic [CMD_W-1:0]  cmd_fifo_rd_data;
    logic              cmd_fifo_valid;
    logic              cmd_fifo_rd_en;
    logic [ADDR_W-1:0] reg_addr;
    logic              reg_rd_en;
    logic [DATA_W-1:0] reg_rd_data;
    logic              reg_wr_en;
    logic [DATA_W-1:0] reg_wr_data;
    logic [7:0]        tx_data;
    logic              tx_data_en;
    logic              tx_busy;
    logic              busy;
    logic [7:0]        err_cnt;

    // Engine side.
    modport master (
        input  cmd_fifo_rd_data, cmd_fifo_valid, reg_rd_data, tx_busy,
        output cmd_fifo_rd_en, reg_addr, reg_rd_en, reg_wr_en, reg_wr_data,
        output tx_data, tx_data_en, busy, err_cnt
    );

    // FIFO / register bank / UART side.
    modport slave (
        output cmd_fifo_rd_data, cmd_fifo_valid, reg_rd_data, tx_busy,
        input  cmd_fifo_rd_en, reg_addr, reg_rd_en, reg_wr_en, reg_wr_data,
        input  tx_data, tx_data_en, busy, err_cnt
    );

endinterface

// File: rtl/resp_byte_sender.sv
// Serialises up to NBYTES bytes of a word, MSB first, into uart_tx using its busy handshake.
module resp_byte_sender #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NB_W   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_word,
    input  logic [NB_W-1:0]   load_nbytes,
    input  logic              tx_busy,
    output logic [7:0]        tx_data,
    output logic              tx_data_en,
    output logic              done
);

    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [NB_W-1:0]   cnt_q, cnt_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              en_q, en_d;
    logic              guard_q, guard_d;
    logic [DATA_W-1:0] cur_word;
    logic [NB_W-1:0]   cur_cnt;
    logic              can_send;

    // Send decision; a load is visible in the same cycle so the first byte costs no extra cycle.
    always_comb begin
        cur_word  = load ? load_word : shreg_q;
        cur_cnt   = load ? load_nbytes : cnt_q;
        // en_q = strobe still pending, guard_q = UART has not raised tx_busy yet.
        can_send  = (cur_cnt != '0) && !tx_busy && !en_q && !guard_q;
        shreg_d   = cur_word;
        cnt_d     = cur_cnt;
        tx_data_d = tx_data_q;
        en_d      = can_send;
        guard_d   = en_q;
        if (can_send) begin
            tx_data_d = cur_word[DATA_W-1 -: 8];
            shreg_d   = cur_word << 8;
            cnt_d     = cur_cnt - NB_W'(1);
        end
    end

    // Byte shift register, remaining count and handshake state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q   <= '0;
            cnt_q     <= '0;
            tx_data_q <= '0;
            en_q      <= 1'b0;
            guard_q   <= 1'b0;
        end else begin
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            tx_data_q <= tx_data_d;
            en_q      <= en_d;
            guard_q   <= guard_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_data_en = en_q;
    assign done       = (cnt_q == '0);

endmodule

// File: rtl/cmd_respond_engine.sv
// Pops commands, performs register read/write/burst-read and streams the response frame to uart_tx.
module cmd_respond_engine
    import cmd_respond_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned NUM_REGS = 256,
    parameter int unsigned LEN_W    = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    cmd_respond_engine_if.master bus
);

    localparam int unsigned NBYTES = DATA_W / 8;
    localparam int unsigned NB_W   = $clog2(NBYTES + 1);
    localparam int unsigned SUM_W  = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;
    localparam int unsigned CMD_W  = 2 + LEN_W + ADDR_W + DATA_W;

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [LEN_W:0]    words_q, words_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    logic [SUM_W-1:0]  last_addr;
    logic              err_now;
    logic              pop;
    logic              snd_load;
    logic [DATA_W-1:0] snd_word;
    logic [NB_W-1:0]   snd_nbytes;
    logic              snd_done;
    logic [7:0]        tx_data;
    logic              tx_data_en;

    // Range check is done one bit wider than the address so a burst can never wrap.
    always_comb begin
        last_addr = SUM_W'(addr_q) + ((op_q == OpBurstRead) ? SUM_W'(len_q) : '0);
        err_now   = (op_q == OpRsvd) || (last_addr >= SUM_W'(NUM_REGS));
    end

    // Next-state and strobe logic.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        len_d         = len_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        err_d         = err_q;
        words_d       = words_q;
        err_cnt_d     = err_cnt_q;
        pop           = 1'b0;
        bus.reg_rd_en = 1'b0;
        bus.reg_wr_en = 1'b0;
        snd_load      = 1'b0;
        snd_word      = '0;
        snd_nbytes    = '0;
        unique case (state_q)
            StIdle: begin
                if (bus.cmd_fifo_valid) begin
                    pop     = 1'b1;
                    op_d    = op_e'(bus.cmd_fifo_rd_data[CMD_W-1 -: 2]);
                    len_d   = bus.cmd_fifo_rd_data[DATA_W+ADDR_W +: LEN_W];
                    addr_d  = bus.cmd_fifo_rd_data[DATA_W +: ADDR_W];
                    wdata_d = bus.cmd_fifo_rd_data[DATA_W-1:0];
                    state_d = StDecode;
                end
            end
            StDecode: begin
                err_d   = err_now;
                words_d = (op_q == OpBurstRead) ? ({1'b0, len_q} + (LEN_W+1)'(1))
                                                : (LEN_W+1)'(1);
                bus.reg_wr_en = !err_now && (op_q == OpWrite);
                if (err_now && (err_cnt_q != 8'hFF)) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
                // Header is armed here so it leaves on the SEND_HDR cycle.
                snd_load   = 1'b1;
                snd_word   = DATA_W'(make_header(err_now, op_q)) << (DATA_W - 8);
                snd_nbytes = NB_W'(1);
                state_d    = StSendHdr;
            end
            StSendHdr: begin
                if (snd_done) begin
                    state_d = (!err_q && (op_q == OpRead || op_q == OpBurstRead)) ? StRdIssue
                                                                                    : StIdle;
                end
            end
            StRdIssue: begin
                bus.reg_rd_en = 1'b1;
                state_d       = StRdCapt;
            end
            StRdCapt: begin
                snd_load   = 1'b1;
                snd_word   = bus.reg_rd_data;
                snd_nbytes = NB_W'(NBYTES);
                state_d    = StSendData;
            end
            StSendData: begin
                if (snd_done) begin
                    words_d = words_q - (LEN_W+1)'(1);
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = (words_q > (LEN_W+1)'(1)) ? StRdIssue : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state and latched command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            op_q      <= OpRead;
            len_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            words_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            len_q     <= len_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            words_q   <= words_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    resp_byte_sender #(
        .DATA_W (DATA_W),
        .NB_W   (NB_W)
    ) u_sender (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (snd_load),
        .load_word   (snd_word),
        .load_nbytes (snd_nbytes),
        .tx_busy     (bus.tx_busy),
        .tx_data     (tx_data),
        .tx_data_en  (tx_data_en),
        .done        (snd_done)
    );

    // Pop is combinational from the FIFO head; keep it quiet while reset is held.
    assign bus.cmd_fifo_rd_en = pop && rst_n;
    assign bus.reg_addr       = addr_q;
    assign bus.reg_wr_data    = wdata_q;
    assign bus.tx_data        = tx_data;
    assign bus.tx_data_en     = tx_data_en;
    assign bus.busy           = (state_q != StIdle);
    assign bus.err_cnt        = err_cnt_q;

endmodule
